// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared encodings, geometry and address field extraction for the read cache
package cache_pkg;

  localparam int          INDEX_BITS = 6;
  localparam int          TAG_BITS   = 10;
  localparam logic [31:0] BASE_ADDR  = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } state_t;

  // Fields are taken from the base-relative address; the subtraction wraps modulo 2^32.
  function automatic logic [INDEX_BITS-1:0] get_index(input logic [31:0] addr);
    return INDEX_BITS'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [TAG_BITS-1:0] get_tag(input logic [31:0] addr);
    return TAG_BITS'((addr - BASE_ADDR) >> (3 + INDEX_BITS));
  endfunction

  function automatic logic get_word(input logic [31:0] addr);
    return 1'((addr - BASE_ADDR) >> 2);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - two-way tag/valid/line storage with per-set LRU bit
module cache_way_array
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_index,
  input  logic                  i_fill_en,
  input  logic                  i_fill_way,
  input  logic [TAG_BITS-1:0]   i_fill_tag,
  input  logic [63:0]           i_fill_data,
  input  logic                  i_word_en,
  input  logic                  i_word_way,
  input  logic                  i_word_sel,
  input  logic [31:0]           i_word_data,
  input  logic                  i_lru_en,
  input  logic                  i_lru_val,
  output logic [1:0]            o_valid,
  output logic [TAG_BITS-1:0]   o_tag0,
  output logic [TAG_BITS-1:0]   o_tag1,
  output logic [63:0]           o_data0,
  output logic [63:0]           o_data1,
  output logic                  o_lru
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]     r_valid0;
  logic [SETS-1:0]     r_valid1;
  logic [SETS-1:0]     r_lru;
  logic [TAG_BITS-1:0] r_tag  [2][SETS];
  logic [63:0]         r_data [2][SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (i_fill_en) begin
        if (i_fill_way) r_valid1[i_index] <= 1'b1;
        else            r_valid0[i_index] <= 1'b1;
      end
      if (i_lru_en) r_lru[i_index] <= i_lru_val;
    end
  end

  // Tag and data are left untouched by reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_way][i_index]  <= i_fill_tag;
      r_data[i_fill_way][i_index] <= i_fill_data;
    end
    if (i_word_en) begin
      if (i_word_sel) r_data[i_word_way][i_index][63:32] <= i_word_data;
      else            r_data[i_word_way][i_index][31:0]  <= i_word_data;
    end
  end

  assign o_valid = {r_valid1[i_index], r_valid0[i_index]};
  assign o_tag0  = r_tag[0][i_index];
  assign o_tag1  = r_tag[1][i_index];
  assign o_data0 = r_data[0][i_index];
  assign o_data1 = r_data[1][i_index];
  assign o_lru   = r_lru[i_index];

endmodule

// File: rtl/sram_read_cache.sv
// rtl/sram_read_cache.sv - two-way write-through, no-write-allocate read cache in front of the SRAM controller
module sram_read_cache
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        cpu_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  state_t                r_state;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_word;
  logic [1:0]            w_valid;
  logic [TAG_BITS-1:0]   w_tag0, w_tag1;
  logic [63:0]           w_data0, w_data1, w_hit_line;
  logic                  w_lru, w_hit0, w_hit1, w_hit, w_victim;
  logic                  w_idle, w_rd_only, w_fill_en, w_word_en, w_lru_en, w_lru_val;

  assign w_index = get_index(cpu_address);
  assign w_tag   = get_tag(cpu_address);
  assign w_word  = get_word(cpu_address);

  assign w_hit0     = w_valid[0] && (w_tag0 == w_tag);
  assign w_hit1     = w_valid[1] && (w_tag1 == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_line = w_hit1 ? w_data1 : w_data0;
  assign w_victim   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : w_lru);

  // A simultaneous load and store is handled as a store.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_rd_only = cpu_rd_en && !cpu_wr_en;
  assign w_fill_en = (r_state == ST_RD_MISS) && sram_ready;
  assign w_word_en = w_idle && cpu_wr_en && w_hit;
  assign w_lru_en  = w_fill_en || w_word_en || (w_idle && w_rd_only && w_hit);
  assign w_lru_val = w_fill_en ? !w_victim : !w_hit1;

  cache_way_array u_ways (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_index),
    .i_fill_en   (w_fill_en),
    .i_fill_way  (w_victim),
    .i_fill_tag  (w_tag),
    .i_fill_data (sram_read_data),
    .i_word_en   (w_word_en),
    .i_word_way  (w_hit1),
    .i_word_sel  (w_word),
    .i_word_data (cpu_write_data),
    .i_lru_en    (w_lru_en),
    .i_lru_val   (w_lru_val),
    .o_valid     (w_valid),
    .o_tag0      (w_tag0),
    .o_tag1      (w_tag1),
    .o_data0     (w_data0),
    .o_data1     (w_data1),
    .o_lru       (w_lru)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_wr_en)               r_state <= ST_WR_THRU;
          else if (cpu_rd_en && !w_hit) r_state <= ST_RD_MISS;
        end
        ST_RD_MISS, ST_WR_THRU: begin
          if (sram_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ready = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (cpu_wr_en)      cpu_ready = 1'b0;
        else if (cpu_rd_en) cpu_ready = w_hit;
      end
      ST_RD_MISS, ST_WR_THRU: cpu_ready = sram_ready;
      default:                cpu_ready = 1'b1;
    endcase
  end

  // A completing miss returns the word straight from the fill bus.
  always_comb begin
    cpu_read_data = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
    if (r_state == ST_RD_MISS)
      cpu_read_data = w_word ? sram_read_data[63:32] : sram_read_data[31:0];
  end

  assign sram_rd_en      = (r_state == ST_RD_MISS);
  assign sram_wr_en      = (r_state == ST_WR_THRU);
  assign sram_address    = cpu_address;
  assign sram_write_data = cpu_write_data;

endmodule
